// File: rtl/turbo_decode_iterative.sv
// rtl/turbo_decode_iterative.sv - iterative turbo decoder controller time-sharing one external SISO engine
module turbo_decode_iterative #(
   parameter int BITS          = 16,
   parameter int N             = 64,
   parameter int NOUT          = 2,
   parameter int TAIL_BITS     = 0,
   parameter int MAX_HALF_ITER = 16,
   parameter int MIN_HALF_ITER = 2,
   parameter int ITER_W        = 5
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [BITS*(2*NOUT-1)*(N+TAIL_BITS)-1:0]       y,
   input  logic [BITS*(N+TAIL_BITS)-1:0]                  sys_il,
   input  logic [ITER_W-1:0]                              cfg_max_half_iter,
   input  logic                                           cfg_early_stop_en,
   output logic                                           siso_start,
   output logic                                           siso_half,
   output logic [BITS*NOUT*(N+TAIL_BITS)-1:0]             siso_enc1,
   output logic [BITS*NOUT*(N+TAIL_BITS)-1:0]             siso_enc2,
   output logic [BITS*NOUT*(N+TAIL_BITS)-1:0]             siso_extrinsic_in,
   input  logic                                           siso_done,
   input  logic [BITS*NOUT*(N+TAIL_BITS)-1:0]             siso_extrinsic_out,
   input  logic [N-1:0]                                   siso_result,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [N-1:0]                                   x,
   output logic [ITER_W-1:0]                              out_half_iters,
   output logic                                           out_early_stop
);

   localparam int SYMBOLS = N + TAIL_BITS;
   localparam int ROW_W   = BITS * SYMBOLS;
   localparam int ARR_W   = ROW_W * NOUT;
   localparam logic [ITER_W-1:0] MAX_I = ITER_W'(MAX_HALF_ITER);
   localparam logic [ITER_W-1:0] MIN_I = ITER_W'(MIN_HALF_ITER);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_CHECK,
      S_OUTPUT
   } state_t;

   state_t              state_q, state_d;
   logic [ITER_W-1:0]   count_q, count_d;
   logic [ITER_W-1:0]   limit_q, limit_d;
   logic                es_en_q, es_en_d;
   logic                early_q, early_d;
   logic [ARR_W-1:0]    enc1_q, enc1_d;
   logic [ARR_W-1:0]    enc2_q, enc2_d;
   logic [ARR_W-1:0]    ext_q, ext_d;
   logic [N-1:0]        cur_q, cur_d;
   logic [N-1:0]        prev_q, prev_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         limit_q <= '0;
         es_en_q <= 1'b0;
         early_q <= 1'b0;
         enc1_q  <= '0;
         enc2_q  <= '0;
         ext_q   <= '0;
         cur_q   <= '0;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         es_en_q <= es_en_d;
         early_q <= early_d;
         enc1_q  <= enc1_d;
         enc2_q  <= enc2_d;
         ext_q   <= ext_d;
         cur_q   <= cur_d;
         prev_q  <= prev_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      limit_d    = limit_q;
      es_en_d    = es_en_q;
      early_d    = early_q;
      enc1_d     = enc1_q;
      enc2_d     = enc2_q;
      ext_d      = ext_q;
      cur_d      = cur_q;
      prev_d     = prev_q;
      in_ready   = 1'b0;
      siso_start = 1'b0;
      out_valid  = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               enc1_d = y[ARR_W-1:0];
               // Tail positions of the interleaved systematic stream carry no information for encoder 2.
               for (int s = 0; s < SYMBOLS; s++) begin
                  enc2_d[s*BITS +: BITS] = (s < N) ? sys_il[s*BITS +: BITS] : '0;
               end
               for (int i = 1; i < NOUT; i++) begin
                  enc2_d[i*ROW_W +: ROW_W] = y[(NOUT-1+i)*ROW_W +: ROW_W];
               end
               ext_d   = '0;
               count_d = '0;
               cur_d   = '0;
               prev_d  = '0;
               early_d = 1'b0;
               es_en_d = cfg_early_stop_en;
               if (cfg_max_half_iter == '0) begin
                  limit_d = ITER_W'(1);
               end else if (cfg_max_half_iter > MAX_I) begin
                  limit_d = MAX_I;
               end else begin
                  limit_d = cfg_max_half_iter;
               end
               state_d = S_START;
            end
         end
         S_START: begin
            siso_start = 1'b1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (siso_done) begin
               ext_d   = siso_extrinsic_out;
               prev_d  = cur_q;
               cur_d   = siso_result;
               count_d = count_q + 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if ((count_q == limit_q) ||
                (es_en_q && (count_q >= MIN_I) && (cur_q == prev_q))) begin
               early_d = (count_q < limit_q);
               state_d = S_OUTPUT;
            end else begin
               state_d = S_START;
            end
         end
         S_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign siso_half         = count_q[0];
   assign siso_enc1         = enc1_q;
   assign siso_enc2         = enc2_q;
   assign siso_extrinsic_in = ext_q;
   assign x                 = (state_q == S_OUTPUT) ? cur_q : '0;
   assign out_half_iters    = (state_q == S_OUTPUT) ? count_q : '0;
   assign out_early_stop    = (state_q == S_OUTPUT) && early_q;

endmodule

// File: tb/tb_turbo_decode_iterative.sv
// tb/tb_turbo_decode_iterative.sv - directed bench for turbo_decode_iterative
module tb_turbo_decode_iterative;

   localparam int BITS  = 8;
   localparam int N     = 8;
   localparam int NOUT  = 2;
   localparam int TAIL  = 3;
   localparam int MAXH  = 16;
   localparam int MINH  = 2;
   localparam int IW    = 5;
   localparam int SYM   = N + TAIL;
   localparam int ROW_W = BITS * SYM;
   localparam int EXT_W = ROW_W * NOUT;
   localparam int Y_W   = ROW_W * 3;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [Y_W-1:0]    y;
   logic [ROW_W-1:0]  sys_il;
   logic [IW-1:0]     cfg_max_half_iter;
   logic              cfg_early_stop_en;
   logic              siso_start;
   logic              siso_half;
   logic [EXT_W-1:0]  siso_enc1;
   logic [EXT_W-1:0]  siso_enc2;
   logic [EXT_W-1:0]  siso_extrinsic_in;
   logic              siso_done;
   logic [EXT_W-1:0]  siso_extrinsic_out;
   logic [N-1:0]      siso_result;
   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      x;
   logic [IW-1:0]     out_half_iters;
   logic              out_early_stop;

   int vectors = 0;
   int miscompares = 0;

   turbo_decode_iterative #(
      .BITS(BITS), .N(N), .NOUT(NOUT), .TAIL_BITS(TAIL),
      .MAX_HALF_ITER(MAXH), .MIN_HALF_ITER(MINH), .ITER_W(IW)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .sys_il(sys_il),
      .cfg_max_half_iter(cfg_max_half_iter), .cfg_early_stop_en(cfg_early_stop_en),
      .siso_start(siso_start), .siso_half(siso_half),
      .siso_enc1(siso_enc1), .siso_enc2(siso_enc2),
      .siso_extrinsic_in(siso_extrinsic_in),
      .siso_done(siso_done), .siso_extrinsic_out(siso_extrinsic_out),
      .siso_result(siso_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .x(x), .out_half_iters(out_half_iters), .out_early_stop(out_early_stop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [IW-1:0] cfg, input logic es);
      @(negedge clk);
      chk("in_ready_before_accept", 512'(in_ready), 512'(1'b1));
      in_valid          = 1'b1;
      cfg_max_half_iter = cfg;
      cfg_early_stop_en = es;
      @(negedge clk);
      in_valid          = 1'b0;
      cfg_max_half_iter = 5'd1;
      cfg_early_stop_en = ~es;
      chk("first_start_latency", 512'(siso_start), 512'(1'b1));
   endtask

   task automatic run_half(input logic exp_half, input logic [N-1:0] res,
                           input logic [EXT_W-1:0] eo, input logic [EXT_W-1:0] exp_ei,
                           input int lat);
      for (int i = 0; i < 50 && !siso_start; i++) @(negedge clk);
      chk("start_seen", 512'(siso_start), 512'(1'b1));
      chk("siso_half", 512'(siso_half), 512'(exp_half));
      chk("extrinsic_in", 512'(siso_extrinsic_in), 512'(exp_ei));
      @(negedge clk);
      chk("start_one_cycle", 512'(siso_start), 512'(1'b0));
      repeat (lat - 1) @(negedge clk);
      siso_done          = 1'b1;
      siso_result        = res;
      siso_extrinsic_out = eo;
      @(negedge clk);
      siso_done = 1'b0;
   endtask

   task automatic wait_out(input logic [N-1:0] exp_x, input logic [IW-1:0] exp_it,
                           input logic exp_es);
      int extra;
      extra = 0;
      for (int i = 0; i < 200 && !out_valid; i++) begin
         if (siso_start) extra++;
         @(negedge clk);
      end
      chk("out_valid", 512'(out_valid), 512'(1'b1));
      chk("x", 512'(x), 512'(exp_x));
      chk("out_half_iters", 512'(out_half_iters), 512'(exp_it));
      chk("out_early_stop", 512'(out_early_stop), 512'(exp_es));
      chk("extra_starts", 512'(extra), 512'(0));
      chk("in_ready_in_output", 512'(in_ready), 512'(1'b0));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("in_ready_after_release", 512'(in_ready), 512'(1'b1));
      chk("x_zero_after_release", 512'(x), 512'(0));
      chk("out_valid_after_release", 512'(out_valid), 512'(1'b0));
   endtask

   initial begin
      logic [EXT_W-1:0] e1, e2, e3, e4, eprev, ecur;
      logic [EXT_W-1:0] exp_enc2;
      logic [N-1:0]     hold_x;
      logic             hold_bad;

      e1 = {22{8'h3C}};
      e2 = {22{8'h5A}};
      e3 = {22{8'hC3}};
      e4 = {22{8'h81}};
      for (int r = 0; r < 3; r++)
         for (int s = 0; s < SYM; s++)
            y[(r*SYM+s)*BITS +: BITS] = 8'(r*16 + s + 1);
      for (int s = 0; s < SYM; s++)
         sys_il[s*BITS +: BITS] = 8'(8'h80 | s);
      exp_enc2 = {y[Y_W-1:EXT_W], 24'h0, sys_il[N*BITS-1:0]};

      reset = 1'b1;
      in_valid = 1'b0;
      cfg_max_half_iter = '0;
      cfg_early_stop_en = 1'b0;
      siso_done = 1'b0;
      siso_extrinsic_out = '0;
      siso_result = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      chk("rst_in_ready", 512'(in_ready), 512'(1'b1));
      chk("rst_out_valid", 512'(out_valid), 512'(1'b0));
      chk("rst_siso_start", 512'(siso_start), 512'(1'b0));
      chk("rst_x", 512'(x), 512'(0));
      chk("rst_iters", 512'(out_half_iters), 512'(0));
      chk("rst_early", 512'(out_early_stop), 512'(1'b0));
      chk("rst_ext", 512'(siso_extrinsic_in), 512'(0));

      // limit 4, no early stop; config changed right after accept
      send_frame(5'd4, 1'b0);
      chk("enc1", 512'(siso_enc1), 512'(y[EXT_W-1:0]));
      chk("enc2", 512'(siso_enc2), 512'(exp_enc2));
      chk("enc2_tail_zero", 512'(siso_enc2[ROW_W-1:N*BITS]), 512'(0));
      run_half(1'b0, 8'h11, e1, '0, 10);
      run_half(1'b1, 8'h22, e2, e1, 10);
      run_half(1'b0, 8'h33, e3, e2, 10);
      run_half(1'b1, 8'h44, e4, e3, 10);
      wait_out(8'h44, 5'd4, 1'b0);
      release_out();

      // early stop: results 01,02,02 stop after 3 of 8
      send_frame(5'd8, 1'b1);
      run_half(1'b0, 8'h01, e1, '0, 4);
      run_half(1'b1, 8'h02, e2, e1, 4);
      run_half(1'b0, 8'h02, e3, e2, 4);
      wait_out(8'h02, 5'd3, 1'b1);
      hold_x = x;
      hold_bad = 1'b0;
      in_valid = 1'b1;
      cfg_max_half_iter = 5'd2;
      repeat (20) begin
         @(negedge clk);
         if (!out_valid || x !== hold_x || in_ready || siso_start) hold_bad = 1'b1;
      end
      in_valid = 1'b0;
      chk("output_hold_stable", 512'(hold_bad), 512'(1'b0));
      chk("hold_iters", 512'(out_half_iters), 512'(5'd3));
      release_out();

      // cfg 0 clamps to one half-iteration
      send_frame(5'd0, 1'b0);
      run_half(1'b0, 8'h5A, e1, '0, 3);
      wait_out(8'h5A, 5'd1, 1'b0);
      release_out();

      // cfg 31 clamps to MAX_HALF_ITER=16
      send_frame(5'd31, 1'b0);
      eprev = '0;
      for (int k = 0; k < 16; k++) begin
         ecur = {22{8'(k + 1)}};
         run_half(1'(k), 8'(k*3 + 1), ecur, eprev, 2);
         eprev = ecur;
      end
      wait_out(8'h2E, 5'd16, 1'b0);
      release_out();

      // reset mid-WAIT, then a stale done
      send_frame(5'd4, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_in_ready", 512'(in_ready), 512'(1'b1));
      siso_done = 1'b1;
      siso_result = 8'hFF;
      siso_extrinsic_out = {22{8'hEE}};
      @(negedge clk);
      siso_done = 1'b0;
      chk("stale_done_in_ready", 512'(in_ready), 512'(1'b1));
      chk("stale_done_out_valid", 512'(out_valid), 512'(1'b0));
      chk("stale_done_x", 512'(x), 512'(0));
      chk("stale_done_ext", 512'(siso_extrinsic_in), 512'(0));
      @(negedge clk);
      chk("stale_done_no_start", 512'(siso_start), 512'(1'b0));

      send_frame(5'd2, 1'b1);
      run_half(1'b0, 8'h77, e1, '0, 5);
      run_half(1'b1, 8'h77, e2, e1, 5);
      wait_out(8'h77, 5'd2, 1'b0);
      release_out();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
